legv8_mc_ctrl: RTL and testbench
================================

LEGV8_MC_CTRL -- requirements
Module: legv8_mc_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 255, meaning the maximum number of cycles to wait for a memory ready before raising fault.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port run, input, 1 bit: when 1, permits leaving S_IDLE.
REQ-005 The block SHALL have ports Uncondbranch, Branch, MemRead, MemWrite, MemtoReg and RegWrite, each input, 1 bit: decoder control bits.
REQ-006 The block SHALL have port cb_invert, input, 1 bit: 1 = CBNZ, 0 = CBZ.
REQ-007 The block SHALL have port zero, input, 1 bit: ALU zero flag, valid in S_EXEC.
REQ-008 The block SHALL have ports imem_ready and dmem_ready, each input, 1 bit: memory completion strobes.
REQ-009 The block SHALL have ports imem_req, ir_write, dmem_req, dmem_we, rf_we, pc_write and pc_src, each output, 1 bit.
REQ-010 The block SHALL have port state, output, 3 bits: current state encoding.
REQ-011 The block SHALL have port retired, output, 32 bits: retired-instruction count.
REQ-012 The block SHALL have port fault, output, 1 bit: sticky timeout flag.

Function
REQ-013 The block SHALL implement the states S_IDLE=0, S_FETCH=1, S_DECODE=2, S_EXEC=3, S_MEM=4, S_WB=5 and S_FAULT=6; the code 7 SHALL go to S_FAULT.
REQ-014 In S_IDLE, run=1 SHALL go to S_FETCH next cycle; otherwise the block SHALL stay in S_IDLE.
REQ-015 In S_FETCH the block SHALL hold imem_req=1; when imem_ready=1 it SHALL pulse ir_write for that same cycle and go to S_DECODE.
REQ-016 S_DECODE SHALL last exactly one cycle, then go to S_EXEC.
REQ-017 S_EXEC SHALL last one cycle; the branch and jump rules in REQ-018 to REQ-020 SHALL take priority, in that order.
REQ-018 In S_EXEC with Uncondbranch=1, the block SHALL assert pc_write=1 and pc_src=1, retire, and go to S_FETCH.
REQ-019 In S_EXEC with Branch=1, the block SHALL evaluate taken=zero^cb_invert, assert pc_write=1 and pc_src=taken, retire, and go to S_FETCH.
REQ-020 In S_EXEC with MemRead|MemWrite, the block SHALL go to S_MEM.
REQ-021 In S_EXEC with RegWrite=1 only, the block SHALL go to S_WB.
REQ-022 In S_EXEC with no control bit set (no-op), the block SHALL assert pc_write=1 and pc_src=0, retire, and go to S_FETCH.
REQ-023 In S_MEM the block SHALL hold dmem_req=1 and dmem_we=MemWrite until dmem_ready.
REQ-024 On dmem_ready in S_MEM, a load SHALL go to S_WB; a store SHALL assert pc_write=1 and pc_src=0, retire, and go to S_FETCH.
REQ-025 S_WB SHALL last one cycle: rf_we=1, pc_write=1, pc_src=0, retire, then go to S_FETCH.
REQ-026 Each S_FETCH and S_MEM visit SHALL start an 8-bit wait counter at 0; while waiting the counter SHALL increment each cycle.
REQ-027 When the wait counter reaches MEM_TIMEOUT without ready, the block SHALL go to S_FAULT and set fault=1.
REQ-028 S_FAULT SHALL be absorbing until reset; in S_FAULT all strobes SHALL be 0.
REQ-029 A ready that arrives on the timeout cycle SHALL win over the timeout.
REQ-030 Retire SHALL increment retired by 1 in the cycle pc_write=1; retired SHALL wrap from 0xFFFFFFFF to 0.
REQ-031 The control inputs SHALL be sampled only in S_EXEC and S_MEM; changes in other states SHALL be ignored.
REQ-032 run=0 SHALL NOT interrupt an instruction in flight; it SHALL be checked only in S_IDLE.
REQ-033 All outputs SHALL be registered-state decodes (Moore), except ir_write, pc_src, and the ready-qualified paths in REQ-015, REQ-024 and REQ-025.
REQ-034 pc_write SHALL be 1 for at most one cycle per instruction.
REQ-035 pc_write and imem_req SHALL never be 1 in the same cycle.

Reset
REQ-036 reset=1 at any clock edge, including mid-wait, SHALL force state=S_IDLE, retired=0, fault=0, wait counter=0, and all strobes to 0 in the following cycle.
REQ-037 A memory transaction in progress when reset is asserted SHALL be abandoned; no retire SHALL occur for it.

Structure
REQ-038 A shared package legv8_pkg SHALL hold the state encodings S_* and the default of MEM_TIMEOUT.
REQ-039 The timeout counter SHALL be the single sub-module legv8_wait_timer (inputs start and tick; output expired).

Verification
REQ-040 The bench SHALL cover: run=1, ADD (RegWrite only), imem_ready after 2 cycles -> states 1,1,1,2,3,5,1, with rf_we=1 in S_WB and retired=1.
REQ-041 The bench SHALL cover: CBNZ with zero=0 -> pc_src=1 and pc_write=1 in S_EXEC; CBZ with zero=0 -> pc_src=0.
REQ-042 The bench SHALL cover: LDUR with dmem_ready after 3 cycles -> dmem_req=1 and dmem_we=0 for 4 cycles, then S_WB with rf_we=1.
REQ-043 The bench SHALL cover: STUR -> dmem_we=1, no rf_we, and retire on the dmem_ready cycle.
REQ-044 The bench SHALL cover: MEM_TIMEOUT=4 with imem_ready held 0 -> state=6 and fault=1 after 4 wait cycles; then reset -> state=0 and fault=0.
REQ-045 The bench SHALL cover: retired preloaded to 0xFFFFFFFF via reset-free force, followed by one no-op -> retired=0.

Source files
------------

// File: rtl/legv8_pkg.sv
// rtl/legv8_pkg.sv - shared state encodings and defaults for the LEGv8 multicycle controller
package legv8_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    localparam int MEM_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/legv8_wait_timer.sv
// rtl/legv8_wait_timer.sv - 8-bit memory wait counter, restarted on each wait-state entry
module legv8_wait_timer
    import legv8_pkg::*;
#(
    parameter int LIMIT = MEM_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic tick,
    output logic expired
);

    logic [7:0] count;

    // Saturates so a stalled count can never wrap back below LIMIT.
    always_ff @(posedge clk) begin
        if (reset || start) begin
            count <= 8'd0;
        end else if (tick && (count != 8'hFF)) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count == LIMIT[7:0]);

endmodule

// File: rtl/legv8_mc_ctrl.sv
// rtl/legv8_mc_ctrl.sv - LEGv8 multicycle control FSM with memory timeout and retire counter
module legv8_mc_ctrl
    import legv8_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        Uncondbranch,
    input  logic        Branch,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemtoReg,
    input  logic        RegWrite,
    input  logic        cb_invert,
    input  logic        zero,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        ir_write,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        rf_we,
    output logic        pc_write,
    output logic        pc_src,
    output logic [2:0]  state,
    output logic [31:0] retired,
    output logic        fault
);

    state_t      state_q;
    state_t      state_d;
    logic [31:0] retired_q;
    logic        expired;
    logic        timer_start;
    logic        timer_tick;
    logic        taken;
    logic        unused_ctrl;

    // Writeback selection is a datapath concern; the controller only routes the load.
    assign unused_ctrl = MemtoReg;
    assign taken       = zero ^ cb_invert;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (run) state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ready)   state_d = S_DECODE;
                else if (expired) state_d = S_FAULT;
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (Uncondbranch || Branch)   state_d = S_FETCH;
                else if (MemRead || MemWrite) state_d = S_MEM;
                else if (RegWrite)            state_d = S_WB;
                else                          state_d = S_FETCH;
            end
            S_MEM: begin
                if (dmem_ready)   state_d = MemRead ? S_WB : S_FETCH;
                else if (expired) state_d = S_FAULT;
            end
            S_WB:     state_d = S_FETCH;
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_FAULT;
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        ir_write = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        pc_write = 1'b0;
        pc_src   = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_write = imem_ready;
            end
            S_EXEC: begin
                if (Uncondbranch) begin
                    pc_write = 1'b1;
                    pc_src   = 1'b1;
                end else if (Branch) begin
                    pc_write = 1'b1;
                    pc_src   = taken;
                end else if (!(MemRead || MemWrite || RegWrite)) begin
                    pc_write = 1'b1;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = MemWrite;
                pc_write = dmem_ready && !MemRead;
            end
            S_WB: begin
                rf_we    = 1'b1;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    // The counter restarts on every fresh entry into a wait state and counts cycles without ready.
    assign timer_start = (state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM));
    assign timer_tick  = ((state_q == S_FETCH) && !imem_ready) || ((state_q == S_MEM) && !dmem_ready);

    legv8_wait_timer #(
        .LIMIT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .start   (timer_start),
        .tick    (timer_tick),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            retired_q <= 32'd0;
        end else if (pc_write) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    assign state   = state_q;
    assign retired = retired_q;
    assign fault   = (state_q == S_FAULT);

endmodule

// File: tb/tb_legv8_mc_ctrl.sv
// tb/tb_legv8_mc_ctrl.sv - randomized self-checking bench for legv8_mc_ctrl
module tb_legv8_mc_ctrl;

    localparam int TMO = 4;
    localparam int K_ADD = 0, K_CBZ = 1, K_CBNZ = 2, K_B = 3, K_LD = 4, K_ST = 5, K_NOP = 6;

    logic clk = 1'b0;
    logic reset, run, Uncondbranch, Branch, MemRead, MemWrite, MemtoReg, RegWrite;
    logic cb_invert, zero, imem_ready, dmem_ready;
    logic imem_req, ir_write, dmem_req, dmem_we, rf_we, pc_write, pc_src, fault;
    logic [2:0]  state;
    logic [31:0] retired;

    typedef struct {
        logic [2:0]  state;
        logic        imem_req, ir_write, dmem_req, dmem_we, rf_we, pc_write, pc_src, fault;
        logic [31:0] retired;
    } exp_t;

    typedef struct {
        logic [2:0] st;
        logic       rf, pw, ps, dreq, dwe;
    } obs_t;

    exp_t        ex;
    logic        ex_on;
    int          checks, errors;
    logic [31:0] model_ret;
    obs_t        trace[$];

    legv8_mc_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .run(run),
        .Uncondbranch(Uncondbranch), .Branch(Branch), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .cb_invert(cb_invert), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_write(ir_write), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .rf_we(rf_we), .pc_write(pc_write), .pc_src(pc_src),
        .state(state), .retired(retired), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (ex_on) begin
            chk("state",    32'(state),    32'(ex.state));
            chk("imem_req", 32'(imem_req), 32'(ex.imem_req));
            chk("ir_write", 32'(ir_write), 32'(ex.ir_write));
            chk("dmem_req", 32'(dmem_req), 32'(ex.dmem_req));
            chk("dmem_we",  32'(dmem_we),  32'(ex.dmem_we));
            chk("rf_we",    32'(rf_we),    32'(ex.rf_we));
            chk("pc_write", 32'(pc_write), 32'(ex.pc_write));
            chk("pc_src",   32'(pc_src),   32'(ex.pc_src));
            chk("fault",    32'(fault),    32'(ex.fault));
            chk("retired",  retired,       ex.retired);
            trace.push_back('{st: state, rf: rf_we, pw: pc_write, ps: pc_src, dreq: dmem_req, dwe: dmem_we});
        end
    end

    function automatic logic rb();
        return $urandom_range(1, 0) == 1;
    endfunction

    function automatic exp_t blank(input int st);
        exp_t e;
        e = '{state: 3'(st), imem_req: 1'b0, ir_write: 1'b0, dmem_req: 1'b0, dmem_we: 1'b0,
              rf_we: 1'b0, pc_write: 1'b0, pc_src: 1'b0, fault: 1'b0, retired: 32'd0};
        return e;
    endfunction

    task automatic rand_ctrl();
        {Uncondbranch, Branch, MemRead, MemWrite, MemtoReg, RegWrite, cb_invert, zero} = 8'($urandom);
    endtask

    task automatic set_ctrl(input int kind);
        {Uncondbranch, Branch, MemRead, MemWrite, MemtoReg, RegWrite, cb_invert} = 7'd0;
        case (kind)
            K_ADD:  RegWrite = 1'b1;
            K_CBZ:  Branch = 1'b1;
            K_CBNZ: begin Branch = 1'b1; cb_invert = 1'b1; end
            K_B:    Uncondbranch = 1'b1;
            K_LD:   begin MemRead = 1'b1; MemtoReg = 1'b1; RegWrite = 1'b1; end
            K_ST:   MemWrite = 1'b1;
            default: ;
        endcase
    endtask

    // One clock of the reference: expected outputs for this cycle, retire counted after the edge.
    task automatic step(input exp_t e, input logic ir, input logic dr);
        e.retired  = model_ret;
        e.fault    = (e.state == 3'd6);
        imem_ready = ir;
        dmem_ready = dr;
        if (e.state != 3'd0) run = rb();
        ex    = e;
        ex_on = 1'b1;
        @(posedge clk);
        #1;
        if (e.pc_write) model_ret = model_ret + 32'd1;
    endtask

    task automatic do_instr(input int kind, input int fd, input int md, input logic z,
                            input int abort, output logic ended);
        exp_t e;
        ended = 1'b0;
        for (int i = 0; i <= TMO; i++) begin
            rand_ctrl();
            e = blank(1);
            e.imem_req = 1'b1;
            e.ir_write = (i == fd);
            step(e, i == fd, rb());
            if (i == fd) break;
        end
        if (fd > TMO) begin
            for (int i = 0; i < 3; i++) begin
                rand_ctrl();
                step(blank(6), rb(), rb());
            end
            ended = 1'b1;
            return;
        end
        rand_ctrl();
        step(blank(2), rb(), rb());
        set_ctrl(kind);
        zero = z;
        e = blank(3);
        if (kind == K_B) begin
            e.pc_write = 1'b1; e.pc_src = 1'b1;
        end else if (kind == K_CBZ || kind == K_CBNZ) begin
            e.pc_write = 1'b1; e.pc_src = z ^ (kind == K_CBNZ);
        end else if (kind == K_NOP) begin
            e.pc_write = 1'b1;
        end
        step(e, rb(), rb());
        if (kind == K_LD || kind == K_ST) begin
            for (int i = 0; i <= TMO; i++) begin
                if (i == abort) begin
                    ended = 1'b1;
                    return;
                end
                zero = rb();
                e = blank(4);
                e.dmem_req = 1'b1;
                e.dmem_we  = (kind == K_ST);
                e.pc_write = (i == md) && (kind == K_ST);
                step(e, rb(), i == md);
                if (i == md) break;
            end
            if (md > TMO) begin
                for (int i = 0; i < 2; i++) step(blank(6), rb(), rb());
                ended = 1'b1;
                return;
            end
        end
        if (kind == K_LD || kind == K_ADD) begin
            rand_ctrl();
            e = blank(5);
            e.rf_we    = 1'b1;
            e.pc_write = 1'b1;
            step(e, rb(), rb());
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ex_on = 1'b0;
        run   = 1'b0;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        model_ret = 32'd0;
        chk("rst_state",    32'(state),    32'd0);
        chk("rst_fault",    32'(fault),    32'd0);
        chk("rst_retired",  retired,       32'd0);
        chk("rst_pc_write", 32'(pc_write), 32'd0);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
    endtask

    task automatic restart();
        do_reset();
        run = 1'b0;
        step(blank(0), rb(), rb());
        run = 1'b1;
        step(blank(0), rb(), rb());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic ended;
        int   n;
        checks = 0; errors = 0; model_ret = 32'd0; ex_on = 1'b0;
        reset = 1'b1; run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        {Uncondbranch, Branch, MemRead, MemWrite, MemtoReg, RegWrite, cb_invert, zero} = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        run = 1'b0;
        repeat (2) step(blank(0), rb(), rb());
        run = 1'b1;
        step(blank(0), rb(), rb());

        trace.delete();
        do_instr(K_ADD, 2, 0, 1'b0, -1, ended);
        chk("add_len", 32'(trace.size()), 32'd6);
        if (trace.size() == 6) begin
            chk("add_s0", 32'(trace[0].st), 32'd1);
            chk("add_s1", 32'(trace[1].st), 32'd1);
            chk("add_s2", 32'(trace[2].st), 32'd1);
            chk("add_s3", 32'(trace[3].st), 32'd2);
            chk("add_s4", 32'(trace[4].st), 32'd3);
            chk("add_s5", 32'(trace[5].st), 32'd5);
            chk("add_rf", 32'(trace[5].rf), 32'd1);
        end
        chk("add_next_state", 32'(state), 32'd1);
        chk("add_retired", retired, 32'd1);

        trace.delete();
        do_instr(K_CBNZ, 0, 0, 1'b0, -1, ended);
        chk("cbnz_pc_src",   32'(trace[2].ps), 32'd1);
        chk("cbnz_pc_write", 32'(trace[2].pw), 32'd1);
        trace.delete();
        do_instr(K_CBZ, 0, 0, 1'b0, -1, ended);
        chk("cbz_pc_src",   32'(trace[2].ps), 32'd0);
        chk("cbz_pc_write", 32'(trace[2].pw), 32'd1);

        trace.delete();
        do_instr(K_LD, 0, 3, 1'b0, -1, ended);
        n = 0;
        foreach (trace[i]) if (trace[i].dreq && !trace[i].dwe) n++;
        chk("ldur_dmem_cycles", 32'(n), 32'd4);
        chk("ldur_wb_state", 32'(trace[trace.size()-1].st), 32'd5);
        chk("ldur_wb_rf",    32'(trace[trace.size()-1].rf), 32'd1);

        trace.delete();
        do_instr(K_ST, 0, 1, 1'b0, -1, ended);
        n = 0;
        foreach (trace[i]) if (trace[i].rf) n++;
        chk("stur_no_rf_we", 32'(n), 32'd0);
        chk("stur_we",       32'(trace[4].dwe), 32'd1);
        chk("stur_retire",   32'(trace[4].pw),  32'd1);
        chk("stur_retired",  retired, 32'd5);

        do_instr(K_NOP, TMO, 0, 1'b0, -1, ended);
        chk("ready_on_timeout_state", 32'(state), 32'd1);
        chk("ready_on_timeout_fault", 32'(fault), 32'd0);

        trace.delete();
        do_instr(K_ADD, TMO + 1, 0, 1'b0, -1, ended);
        n = 0;
        foreach (trace[i]) if (trace[i].st == 3'd1) n++;
        chk("timeout_fetch_cycles", 32'(n), 32'(TMO + 1));
        chk("timeout_state", 32'(state), 32'd6);
        chk("timeout_fault", 32'(fault), 32'd1);
        restart();

        do_instr(K_NOP, 0, 0, 1'b0, -1, ended);
        do_instr(K_LD, 0, TMO, 1'b0, 2, ended);
        restart();
        do_instr(K_ST, TMO, TMO, 1'b0, -1, ended);
        chk("post_abort_retired", retired, 32'd1);

        force dut.retired_q = 32'hFFFF_FFFF;
        #2;
        release dut.retired_q;
        model_ret = 32'hFFFF_FFFF;
        do_instr(K_NOP, 0, 0, 1'b0, -1, ended);
        chk("retired_wrap", retired, 32'd0);

        for (int k = 0; k < 40; k++) begin
            int fd, md;
            fd = ($urandom_range(9, 0) == 0) ? TMO + 1 : int'($urandom_range(TMO, 0));
            md = ($urandom_range(9, 0) == 0) ? TMO + 1 : int'($urandom_range(TMO, 0));
            do_instr(int'($urandom_range(6, 0)), fd, md, rb(), -1, ended);
            if (ended) restart();
        end

        ex_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
